fp_accum: RTL and testbench
===========================

FP_ACCUM -- requirements
Module: fp_accum

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the beat counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, the upstream operand is valid.
REQ-005 SHALL have port in_ready, output, 1, the block accepts an operand this cycle.
REQ-006 SHALL have port in_data, input, 64, IEEE-754 double operand.
REQ-007 SHALL have port in_last, input, 1, marks the final operand of a stream; qualified by accept.
REQ-008 SHALL have port out_valid, output, 1, the stream sum is available.
REQ-009 SHALL have port out_ready, input, 1, the downstream takes the sum.
REQ-010 SHALL have port out_sum, output, 64, IEEE-754 double sum of the stream.
REQ-011 SHALL have port out_count, output, CNT_W, number of operands accepted in the stream.
REQ-012 SHALL have port out_nan, output, 1, sticky: any accepted operand or partial sum was NaN.
REQ-013 SHALL have port out_inf, output, 1, out_sum is ±infinity.

Function
REQ-014 SHALL define accept as in_valid AND in_ready, sampled at the rising edge of clk.
REQ-015 SHALL instantiate the team's combinational fp_add (a, b -> result) with a = accumulator and b = in_data.
REQ-016 SHALL NOT apply any extra rounding or normalization to the fp_add result.
REQ-017 SHALL implement the FSM states IDLE, ACC and HOLD.
REQ-018 IDLE: in_ready=1 and out_valid=0; on accept the accumulator SHALL load in_data directly, bypassing fp_add so that -0.0 is preserved, and the count SHALL become 1.
REQ-019 From IDLE, an accept with in_last=1 SHALL go to HOLD; an accept with in_last=0 SHALL go to ACC.
REQ-020 ACC: in_ready=1; on accept the accumulator SHALL load the fp_add result and the count SHALL increment.
REQ-021 From ACC, an accept with in_last=1 SHALL go to HOLD; with no accept the block SHALL stay in ACC and hold all state.
REQ-022 HOLD: in_ready=0, out_valid=1, out_sum=accumulator and out_count=count.
REQ-023 HOLD SHALL move to IDLE on the first cycle with out_ready=1; out_valid SHALL be 0 on the next cycle.
REQ-024 The sum SHALL be valid 1 cycle after the accept of the last beat.
REQ-025 No operand SHALL be accepted in the cycle the result is consumed, so one stream never overlaps the next.
REQ-026 While out_valid=1 and out_ready=0, out_sum, out_count, out_nan and out_inf SHALL stay stable.
REQ-027 The count SHALL saturate at 2^CNT_W-1 and not wrap; accumulation SHALL continue past saturation.
REQ-028 out_nan SHALL be set when an accepted in_data is NaN or when a loaded fp_add result is NaN.
REQ-029 out_nan SHALL stay set until the stream is consumed or reset; it SHALL clear on the IDLE load of a non-NaN operand.
REQ-030 out_inf SHALL equal (exponent==0x7FF AND fraction==0) of out_sum.
REQ-031 A NaN result SHALL be the fp_add canonical quiet NaN 0x7FF8000000000000.
REQ-032 When in_valid=1 and in_last=1 in IDLE, the single operand SHALL be the result, with count 1.
REQ-033 in_data and in_last SHALL be ignored whenever in_ready=0.

Reset
REQ-034 With rst=1 at a clock edge, the block SHALL enter IDLE with accumulator=0, count=0, out_valid=0, out_nan=0, out_inf=0, in_ready=1 on the following cycle.
REQ-035 Reset SHALL take priority over a simultaneous accept or consume.
REQ-036 Reset in ACC or HOLD SHALL discard the partial or pending sum without emitting it.

Verification
REQ-037 Beats 0x3FF0000000000000 then 0x4000000000000000 (last) -> one cycle later out_valid=1, out_sum=0x4008000000000000, out_count=2, out_nan=0.
REQ-038 Single beat 0x8000000000000000 with last -> out_sum=0x8000000000000000, out_count=1.
REQ-039 Beats 0x7FF0000000000000 then 0xFFF0000000000000 (last) -> out_sum=0x7FF8000000000000, out_nan=1, out_inf=0.
REQ-040 Hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> out_valid=1, out_sum unchanged, in_ready=0 throughout, no beat consumed.
REQ-041 Assert rst after 2 accepted beats, then send 0x3FE0000000000000 with last -> out_sum=0x3FE0000000000000, out_count=1, no earlier out_valid.
REQ-042 Beats 0x3FF0000000000000 then 0xBFF0000000000000 (last) with in_valid gaps between beats -> out_sum=0x0000000000000000, out_count=2.

Source files
------------

// File: rtl/fp_accum.sv
// Streaming IEEE-754 double accumulator.
// fp_add   : combinational double-precision adder, round-to-nearest-even,
//            gradual underflow, canonical quiet NaN on invalid operations.
// fp_accum : sums a valid/ready stream of doubles. The stream sum is held
//            until downstream takes it, and then the next stream may begin.

module fp_add (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] result
);

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    // Count leading zeros of the 56-bit working mantissa (56 when all zero).
    function automatic logic [5:0] lzc56(input logic [55:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = 55; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 6'd1;
                end
            end
        end
        return n;
    endfunction

    logic        sa_s, sb_s;
    logic [10:0] ea_s, eb_s;
    logic [51:0] fa_s, fb_s;
    logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s;
    logic        swap_s, eff_sub_s, big_sign_s, sticky_s, round_up_s;
    logic [10:0] big_exp_s, small_exp_s, diff_s;
    logic [52:0] big_m_s, small_m_s, mant_f_s;
    logic [55:0] big_ext_s, small_ext_s, shifted_s, lost_mask_s, aligned_s, norm_s;
    logic [56:0] sum_s;
    logic [12:0] exp_w_s, lshift_s, exp_f_s;
    logic [5:0]  lz_s;
    logic [53:0] rnd_s;

    // Align, add/subtract, normalise, round and select special-case results.
    always_comb begin
        sa_s    = a[63];
        sb_s    = b[63];
        ea_s    = a[62:52];
        eb_s    = b[62:52];
        fa_s    = a[51:0];
        fb_s    = b[51:0];
        a_nan_s = (ea_s == 11'h7FF) && (fa_s != 52'd0);
        b_nan_s = (eb_s == 11'h7FF) && (fb_s != 52'd0);
        a_inf_s = (ea_s == 11'h7FF) && (fa_s == 52'd0);
        b_inf_s = (eb_s == 11'h7FF) && (fb_s == 52'd0);

        // Larger magnitude goes first so the subtraction never goes negative.
        swap_s    = b[62:0] > a[62:0];
        eff_sub_s = sa_s ^ sb_s;
        if (swap_s) begin
            big_sign_s  = sb_s;
            big_exp_s   = (eb_s == 11'd0) ? 11'd1 : eb_s;
            small_exp_s = (ea_s == 11'd0) ? 11'd1 : ea_s;
            big_m_s     = {(eb_s != 11'd0), fb_s};
            small_m_s   = {(ea_s != 11'd0), fa_s};
        end else begin
            big_sign_s  = sa_s;
            big_exp_s   = (ea_s == 11'd0) ? 11'd1 : ea_s;
            small_exp_s = (eb_s == 11'd0) ? 11'd1 : eb_s;
            big_m_s     = {(ea_s != 11'd0), fa_s};
            small_m_s   = {(eb_s != 11'd0), fb_s};
        end

        // Three extra low bits act as guard, round and sticky.
        diff_s      = big_exp_s - small_exp_s;
        big_ext_s   = {big_m_s, 3'b000};
        small_ext_s = {small_m_s, 3'b000};
        lost_mask_s = 56'd0;
        if (diff_s >= 11'd56) begin
            shifted_s = 56'd0;
            sticky_s  = |small_m_s;
        end else begin
            shifted_s   = small_ext_s >> diff_s;
            lost_mask_s = ~({56{1'b1}} << diff_s);
            sticky_s    = |(small_ext_s & lost_mask_s);
        end
        aligned_s = {shifted_s[55:1], shifted_s[0] | sticky_s};

        if (eff_sub_s) begin
            sum_s = {1'b0, big_ext_s} - {1'b0, aligned_s};
        end else begin
            sum_s = {1'b0, big_ext_s} + {1'b0, aligned_s};
        end

        // Normalise: carry-out shifts right; cancellation shifts left but
        // never below exponent 1, which leaves a subnormal pattern.
        exp_w_s  = {2'b00, big_exp_s};
        lz_s     = 6'd0;
        lshift_s = 13'd0;
        if (sum_s[56]) begin
            norm_s  = {sum_s[56:2], sum_s[1] | sum_s[0]};
            exp_w_s = exp_w_s + 13'd1;
        end else begin
            lz_s = lzc56(sum_s[55:0]);
            if ({7'd0, lz_s} > (exp_w_s - 13'd1)) begin
                lshift_s = exp_w_s - 13'd1;
            end else begin
                lshift_s = {7'd0, lz_s};
            end
            norm_s  = sum_s[55:0] << lshift_s;
            exp_w_s = exp_w_s - lshift_s;
        end

        // Round to nearest, ties to even.
        round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        rnd_s      = {1'b0, norm_s[55:3]} + {53'd0, round_up_s};
        if (rnd_s[53]) begin
            mant_f_s = rnd_s[53:1];
            exp_f_s  = exp_w_s + 13'd1;
        end else begin
            mant_f_s = rnd_s[52:0];
            exp_f_s  = exp_w_s;
        end

        if (a_nan_s || b_nan_s) begin
            result = QNAN;
        end else if (a_inf_s && b_inf_s) begin
            result = (sa_s == sb_s) ? a : QNAN;
        end else if (a_inf_s) begin
            result = a;
        end else if (b_inf_s) begin
            result = b;
        end else if (norm_s == 56'd0) begin
            // Exact zero: -0 only when both operands were -0.
            result = {(~eff_sub_s) & sa_s, 63'd0};
        end else if (exp_f_s >= 13'h7FF) begin
            result = {big_sign_s, 11'h7FF, 52'd0};
        end else begin
            result = {big_sign_s, (mant_f_s[52] ? exp_f_s[10:0] : 11'd0), mant_f_s[51:0]};
        end
    end

endmodule

module fp_accum #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan,
    output logic             out_inf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    state_t            state_q, state_d;
    logic [63:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              nan_q, nan_d;
    logic              inf_q, inf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              accept_s;
    logic [63:0]       add_res_s;

    fp_add u_fp_add (
        .a      (acc_q),
        .b      (in_data),
        .result (add_res_s)
    );

    assign accept_s  = in_valid & in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_nan   = nan_q;
    assign out_inf   = inf_q;

    // Next-state, accumulator, beat counter and NaN flag.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        nan_d   = nan_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    // First beat bypasses the adder so -0.0 survives.
                    acc_d   = in_data;
                    cnt_d   = CNT_ONE;
                    nan_d   = is_nan(in_data);
                    state_d = in_last ? HOLD : ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (accept_s) begin
                    acc_d = add_res_s;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    nan_d   = nan_q | is_nan(in_data) | is_nan(add_res_s);
                    state_d = in_last ? HOLD : ACC;
                end else begin
                    state_d = ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    nan_d   = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d != HOLD);
        out_valid_d = (state_d == HOLD);
        inf_d       = (acc_d[62:52] == 11'h7FF) && (acc_d[51:0] == 52'd0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 64'd0;
            cnt_q       <= {CNT_W{1'b0}};
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            nan_q       <= nan_d;
            inf_q       <= inf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum, built with a 3-bit beat counter so that
// saturation is reachable in a few beats.

module tb_fp_accum;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_sum;
    logic [CW-1:0] out_count;
    logic          out_nan;
    logic          out_inf;

    int checks = 0;
    int errors = 0;

    fp_accum #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_nan   (out_nan),
        .out_inf   (out_inf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [63:0] sum, input logic [63:0] cnt,
                              input logic nan, input logic inf);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_sum"}, out_sum, sum);
        chk({tag, "_count"}, 64'(out_count), cnt);
        chk({tag, "_nan"}, 64'(out_nan), 64'(nan));
        chk({tag, "_inf"}, 64'(out_inf), 64'(inf));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_sum", out_sum, 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        chk("rst_nan", 64'(out_nan), 64'd0);
        chk("rst_inf", 64'(out_inf), 64'd0);

        // 1.0 + 2.0 = 3.0, valid one cycle after the last accept
        beat(64'h3FF0_0000_0000_0000, 1'b0);
        chk("add_mid_valid", 64'(out_valid), 64'd0);
        beat(64'h4000_0000_0000_0000, 1'b1);
        chk_result("add12", 64'h4008_0000_0000_0000, 64'd2, 1'b0, 1'b0);
        consume("add12");

        // Single -0.0 beat keeps its sign
        beat(64'h8000_0000_0000_0000, 1'b1);
        chk_result("negzero", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b0);
        consume("negzero");

        // +inf + -inf -> canonical quiet NaN
        beat(64'h7FF0_0000_0000_0000, 1'b0);
        beat(64'hFFF0_0000_0000_0000, 1'b1);
        chk_result("infnan", 64'h7FF8_0000_0000_0000, 64'd2, 1'b1, 1'b0);
        consume("infnan");
        chk("nan_cleared", 64'(out_nan), 64'd0);

        // Single +inf beat flags out_inf
        beat(64'h7FF0_0000_0000_0000, 1'b1);
        chk_result("posinf", 64'h7FF0_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        consume("posinf");

        // Backpressure: result stable, no beat taken while held or on consume
        beat(64'h3FF0_0000_0000_0000, 1'b1);
        in_valid = 1'b1;
        in_data  = 64'h4010_0000_0000_0000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_result("stall", 64'h3FF0_0000_0000_0000, 64'd1, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stall_drop_valid", 64'(out_valid), 64'd0);
        chk("stall_idle_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_result("after_stall", 64'h4010_0000_0000_0000, 64'd1, 1'b0, 1'b0);
        consume("after_stall");

        // Reset mid-stream, with an accept offered on the reset edge
        beat(64'h3FF0_0000_0000_0000, 1'b0);
        chk("mid1_valid", 64'(out_valid), 64'd0);
        beat(64'h4000_0000_0000_0000, 1'b0);
        chk("mid2_valid", 64'(out_valid), 64'd0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'h4020_0000_0000_0000;
        in_last  = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_count", 64'(out_count), 64'd0);
        chk("mrst_sum", out_sum, 64'd0);
        beat(64'h3FE0_0000_0000_0000, 1'b1);
        chk_result("post_rst", 64'h3FE0_0000_0000_0000, 64'd1, 1'b0, 1'b0);
        consume("post_rst");

        // 1.0 + -1.0 with idle gaps -> +0.0
        beat(64'h3FF0_0000_0000_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_valid", 64'(out_valid), 64'd0);
            chk("gap_ready", 64'(in_ready), 64'd1);
        end
        beat(64'hBFF0_0000_0000_0000, 1'b1);
        chk_result("cancel", 64'h0000_0000_0000_0000, 64'd2, 1'b0, 1'b0);
        consume("cancel");

        // 1.5 + -1.25 = 0.25 (left normalisation)
        beat(64'h3FF8_0000_0000_0000, 1'b0);
        beat(64'hBFF4_0000_0000_0000, 1'b1);
        chk_result("renorm", 64'h3FD0_0000_0000_0000, 64'd2, 1'b0, 1'b0);
        consume("renorm");

        // 1.0 + 2^-53: exact tie rounds to even
        beat(64'h3FF0_0000_0000_0000, 1'b0);
        beat(64'h3CA0_0000_0000_0000, 1'b1);
        chk_result("tie_even", 64'h3FF0_0000_0000_0000, 64'd2, 1'b0, 1'b0);
        consume("tie_even");

        // 1.0 + just over 2^-53: rounds up one ulp
        beat(64'h3FF0_0000_0000_0000, 1'b0);
        beat(64'h3CA0_0000_0000_0001, 1'b1);
        chk_result("round_up", 64'h3FF0_0000_0000_0001, 64'd2, 1'b0, 1'b0);
        consume("round_up");

        // Nine beats of 1.0: count saturates at 7, sum keeps going to 9.0
        for (int i = 0; i < 8; i++) begin
            beat(64'h3FF0_0000_0000_0000, 1'b0);
        end
        chk("sat_mid_count", 64'(out_count), 64'd7);
        beat(64'h3FF0_0000_0000_0000, 1'b1);
        chk_result("sat", 64'h4022_0000_0000_0000, 64'd7, 1'b0, 1'b0);
        consume("sat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
